// File: rtl/multi_bit_comparator_serialized.sv
// Bit-serial magnitude comparator for two unsigned (n+1)-bit operands.
// Samples both operands in LOAD, then walks them MSB-first one bit per
// clock in COMPARE. The first differing bit decides the result. The one-hot
// result is registered on the final COMPARE edge and held until the next
// completion. The block free-runs: every LOAD starts a new comparison.
// An all-zero output means no comparison has completed since reset.
// state_dbg exposes the FSM state so that checkers can follow the walk.
module multi_bit_comparator_serialized #(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n:0]   a_in,
    input  logic [n:0]   b_in,
    output logic         less_than,
    output logic         equal_to,
    output logic         greater_than,
    output logic         state_dbg
);

    // The bit index needs to count n..0, and it always has at least one bit.
    localparam int IW = (n + 1 > 1) ? $clog2(n + 1) : 1;

    typedef enum logic {
        LOAD    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [n:0]      a_q;
    logic [n:0]      b_q;
    logic [IW-1:0]   idx;
    logic            decided;
    logic            a_gt;

    // Decision after taking the current bit into account. These values feed
    // the sticky flags and also the outputs on the last bit, so the bit-0
    // decision is part of the published result.
    logic            bit_a;
    logic            bit_b;
    logic            decided_now;
    logic            a_gt_now;
    logic            last_bit;

    assign state_dbg = state;

    // Look at the current bit pair and work out the decision including it.
    always_comb begin
        bit_a       = a_q[idx];
        bit_b       = b_q[idx];
        decided_now = decided | (bit_a ^ bit_b);
        a_gt_now    = decided ? a_gt : bit_a;
        last_bit    = (idx == '0);
    end

    // State register. An asynchronous reset discards any partial comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one LOAD cycle, then one COMPARE cycle per bit.
    always_comb begin
        next_state = state;
        case (state)
            LOAD:    next_state = COMPARE;
            COMPARE: next_state = last_bit ? LOAD : COMPARE;
            default: next_state = LOAD;
        endcase
    end

    // Operand shadows, bit index and sticky decision flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            a_gt    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    a_q     <= a_in;
                    b_q     <= b_in;
                    idx     <= IW'(n);
                    decided <= 1'b0;
                    a_gt    <= 1'b0;
                end
                COMPARE: begin
                    // Once decided, later bits leave the flags untouched.
                    decided <= decided_now;
                    a_gt    <= a_gt_now;
                    if (!last_bit) begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    // Result registers: written only on the final COMPARE edge, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            less_than    <= 1'b0;
            equal_to     <= 1'b0;
            greater_than <= 1'b0;
        end else if (state == COMPARE && last_bit) begin
            less_than    <= decided_now & ~a_gt_now;
            equal_to     <= ~decided_now;
            greater_than <= decided_now & a_gt_now;
        end
    end

endmodule

// File: tb/tb_multi_bit_comparator_serialized.sv
// Directed and swept checks for the bit-serial comparator at n = 3.
// Results are packed as {less_than, equal_to, greater_than}.
module tb_multi_bit_comparator_serialized;

    localparam int N = 3;
    localparam int W = N + 1;

    logic         clk;
    logic         reset;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         less_than;
    logic         equal_to;
    logic         greater_than;
    logic         state_dbg;

    int errors;
    int checks;

    logic [2:0] exp_q[$];
    logic [2:0] held;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   exp;
    } vec_t;

    vec_t vecs[12];

    multi_bit_comparator_serialized #(.n(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_in         (a_in),
        .b_in         (b_in),
        .less_than    (less_than),
        .equal_to     (equal_to),
        .greater_than (greater_than),
        .state_dbg    (state_dbg)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] outs();
        return {less_than, equal_to, greater_than};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one full comparison, entered and left at a falling edge right
    // before a LOAD edge. Outputs must hold through LOAD and the first n
    // COMPARE edges, then update on edge n+2 relative to LOAD at edge 1.
    // When chg is set the operands are swapped to (ma, mb) after LOAD.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic chg, input logic [W-1:0] ma, input logic [W-1:0] mb,
                           input logic [2:0] exp, input string name);
        logic [2:0] got;
        a_in = a;
        b_in = b;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        check({name, " hold@load"}, outs(), held);
        if (chg) begin
            a_in = ma;
            b_in = mb;
        end
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " hold@cmp"}, outs(), held);
        end
        @(posedge clk);
        @(negedge clk);
        got = outs();
        check({name, " result"}, got, exp_q.pop_front());
        checks++;
        if (!$onehot(got)) begin
            errors++;
            $display("FAIL %s onehot: got %b expected one-hot", name, got);
        end
        held = exp;
    endtask

    // Driver: start a comparison, abort it after k COMPARE edges with an
    // asynchronous reset, and release reset at a falling edge.
    task automatic abort_with_reset(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        a_in = a;
        b_in = b;
        @(posedge clk);
        for (int i = 0; i < k; i++) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async reset clears", outs(), 3'b000);
        checks++;
        if (state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset state: got %b expected 0", state_dbg);
        end
        @(posedge clk);
        @(negedge clk);
        check("reset held zero", outs(), 3'b000);
        reset = 1'b0;
        held = 3'b000;
    endtask

    initial begin
        logic [2:0] e;
        errors = 0;
        checks = 0;
        held   = 3'b000;
        reset  = 1'b1;
        a_in   = '0;
        b_in   = '0;

        vecs[0]  = '{a: 4'hA, b: 4'hB, exp: 3'b100};
        vecs[1]  = '{a: 4'h8, b: 4'h7, exp: 3'b001};
        vecs[2]  = '{a: 4'h7, b: 4'h8, exp: 3'b100};
        vecs[3]  = '{a: 4'h5, b: 4'h5, exp: 3'b010};
        vecs[4]  = '{a: 4'hF, b: 4'hF, exp: 3'b010};
        vecs[5]  = '{a: 4'h0, b: 4'h0, exp: 3'b010};
        vecs[6]  = '{a: 4'h0, b: 4'hF, exp: 3'b100};
        vecs[7]  = '{a: 4'hF, b: 4'h0, exp: 3'b001};
        vecs[8]  = '{a: 4'h3, b: 4'h2, exp: 3'b001};
        vecs[9]  = '{a: 4'h6, b: 4'hC, exp: 3'b100};
        vecs[10] = '{a: 4'hE, b: 4'hF, exp: 3'b100};
        vecs[11] = '{a: 4'h1, b: 4'h0, exp: 3'b001};

        repeat (2) @(negedge clk);
        check("reset outputs", outs(), 3'b000);
        reset = 1'b0;

        // Table-driven vectors, back to back with no gap between comparisons.
        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i].a, vecs[i].b, 1'b0, '0, '0, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Operands changed during COMPARE do not affect the current result.
        run_one(4'h1, 4'h2, 1'b1, 4'h9, 4'h2, 3'b100, "midchange cur");
        run_one(4'h9, 4'h2, 1'b0, '0, '0, 3'b001, "midchange next");

        // Reset mid-comparison while a nonzero result is showing.
        abort_with_reset(4'h3, 4'h3, 2);
        run_one(4'hA, 4'hB, 1'b0, '0, '0, 3'b100, "after reset");

        // Exhaustive sweep with random reset pulses.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 19) == 0) begin
                    abort_with_reset(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                                     int'($urandom_range(0, 3)));
                end
                e = {a < b, a == b, a > b};
                run_one(W'(a), W'(b), 1'b0, '0, '0, e, $sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
